system_ram_arbiter: RTL and testbench

- Two-master round-robin arbiter that shares the single-port on-chip RAM (2048 x 32, byte-enabled) between the Nios CPU data master (m0) and the display-refresh/alarm-scan DMA master (m1).
- Presents an Avalon-MM pipelined slave port per master: waitrequest plus readdatavalid.
- Drives the RAM's single port. RAM read latency is 1 cycle, since the address is registered and the q output is unregistered.

---
 rtl/system_ram_arbiter.sv | 113 +++++++++++
 tb/tb_system_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_ram_arbiter.sv
// Two-master round-robin arbiter for the shared single-port system RAM (Avalon-MM pipelined slaves).
// Optional m0 bus lock is enabled by defining SYSTEM_RAM_ARB_LOCK_EN.
module system_ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef SYSTEM_RAM_ARB_LOCK_EN
  input  logic              m0_lock,
`endif
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic req0, req1, lock_act, gnt0, gnt1;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic last_grant_q, last_grant_d;

  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    lock_act = 1'b0;
`ifdef SYSTEM_RAM_ARB_LOCK_EN
    // Lock only holds once m0 owns the last accepted access.
    lock_act = m0_lock & ~last_grant_q;
`endif
    gnt0 = reset_n & req0 & (~req1 | last_grant_q | lock_act);
    gnt1 = reset_n & req1 & ~lock_act & (~req0 | ~last_grant_q);

    // Write wins when read and write are both asserted.
    rd_pend_d    = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
    rd_owner_d   = rd_owner_q;
    last_grant_d = last_grant_q;
    if (gnt1) begin
      rd_owner_d   = 1'b1;
      last_grant_d = 1'b1;
    end else if (gnt0) begin
      rd_owner_d   = 1'b0;
      last_grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    m0_waitrequest   = ~reset_n | (req0 & ~gnt0);
    m1_waitrequest   = ~reset_n | (req1 & ~gnt1);
    m0_readdatavalid = reset_n & rd_pend_q & ~rd_owner_q;
    m1_readdatavalid = reset_n & rd_pend_q & rd_owner_q;
    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
    ram_clken        = reset_n;
    ram_chipselect   = gnt0 | gnt1;
    ram_write        = (gnt0 & m0_write) | (gnt1 & m1_write);
    // Losing master's address and data never reach the RAM pins.
    ram_address      = '0;
    ram_byteenable   = '0;
    ram_writedata    = '0;
    if (gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end else if (gnt0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(m0_read && m0_write)) else $error("m0 read and write asserted together");
      assert (!(m1_read && m1_write)) else $error("m1 read and write asserted together");
    end
  end
`endif

endmodule

// File: tb/tb_system_ram_arbiter.sv
// Self-checking bench for system_ram_arbiter: RAM model, transaction-level arbiter model, directed tests.
// Lock tests are included when SYSTEM_RAM_ARB_LOCK_EN is defined.
module tb_system_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
`ifdef SYSTEM_RAM_ARB_LOCK_EN
  logic        m0_lock = 1'b0;
`endif
  logic [10:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  system_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SYSTEM_RAM_ARB_LOCK_EN
    .m0_lock(m0_lock),
`endif
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  // RAM: registered address, unregistered q.
  logic [31:0] mem [0:2047];
  logic [10:0] ram_addr_r = '0;
  assign ram_readdata = mem[ram_addr_r];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      ram_addr_r <= ram_address;
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
    end
  end

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE0000 + i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] shadow [0:2047];
  int          last_winner = 1;
  bit          pend = 0;
  int          pend_owner = 0;
  logic [31:0] pend_data = '0;
  int          rdv_cnt [2] = '{0, 0};

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = init_val(i);
      shadow[i] = init_val(i);
    end
  end

  initial begin
    int w;
    bit locked, r0, r1, rd;
    logic [10:0] a;
    logic [3:0] be;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      locked = 0;
`ifdef SYSTEM_RAM_ARB_LOCK_EN
      locked = m0_lock && last_winner == 0;
`endif
      w = -1;
      if (reset_n) begin
        if (r0 && r1) w = locked ? 0 : (last_winner == 0 ? 1 : 0);
        else if (r0) w = 0;
        else if (r1 && !locked) w = 1;
      end
      if (!reset_n) pend = 0;
      chk("m0_waitrequest", m0_waitrequest, !reset_n || (r0 && w != 0));
      chk("m1_waitrequest", m1_waitrequest, !reset_n || (r1 && w != 1));
      chk("ram_chipselect", ram_chipselect, w >= 0);
      chk("ram_clken", ram_clken, reset_n);
      chk("m0_readdatavalid", m0_readdatavalid, pend && pend_owner == 0);
      chk("m1_readdatavalid", m1_readdatavalid, pend && pend_owner == 1);
      if (pend) begin
        chk(pend_owner == 0 ? "m0_readdata" : "m1_readdata",
            pend_owner == 0 ? m0_readdata : m1_readdata, pend_data);
        rdv_cnt[pend_owner]++;
      end
      rd = 0; a = '0; be = '0; d = '0;
      if (w == 0) begin rd = !m0_write; a = m0_address; be = m0_byteenable; d = m0_writedata; end
      if (w == 1) begin rd = !m1_write; a = m1_address; be = m1_byteenable; d = m1_writedata; end
      chk("ram_write", ram_write, w >= 0 && !rd);
      chk("ram_address", ram_address, a);
      chk("ram_byteenable", ram_byteenable, be);
      if (w >= 0 && !rd) chk("ram_writedata", ram_writedata, d);
      @(posedge clk);
      if (!reset_n) begin
        pend = 0;
        last_winner = 1;
      end else begin
        pend = 0;
        if (w >= 0) begin
          last_winner = w;
          if (rd) begin
            pend = 1;
            pend_owner = w;
            pend_data = shadow[a];
          end else begin
            for (int b = 0; b < 4; b++)
              if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input bit m, input bit wr, input logic [10:0] a, input logic [3:0] be,
                     input logic [31:0] d, output logic [31:0] rdat, output int waits);
    bit done;
    @(posedge clk); #1;
    rdat = 'x;
    if (m == 0) begin
      m0_address = a; m0_byteenable = be; m0_writedata = d; m0_write = wr; m0_read = !wr;
    end else begin
      m1_address = a; m1_byteenable = be; m1_writedata = d; m1_write = wr; m1_read = !wr;
    end
    done = 0;
    waits = 0;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      if ((m == 0 && !m0_waitrequest) || (m == 1 && !m1_waitrequest)) done = 1;
      else waits++;
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    if (!wr) begin
      done = 0;
      for (int n = 0; n < 4 && !done; n++) begin
        @(negedge clk);
        if (m == 0 && m0_readdatavalid) begin rdat = m0_readdata; done = 1; end
        if (m == 1 && m1_readdatavalid) begin rdat = m1_readdata; done = 1; end
      end
      if (!done) chk("readdatavalid_timeout", 0, 1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int waits, i0, i1, prev_w, cur_w, c0, c1, pulses;
    bit a0, a1, alt_ok;

    // Reset with requests active
    m0_read = 1; m1_write = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_cs", ram_chipselect, 0);
      chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    end
    @(posedge clk); #1;
    reset_n = 1; m0_read = 0; m1_write = 0;
    m0_write = 1; m0_address = 11'h010; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
    @(negedge clk);
    chk("first_wr_accept", m0_waitrequest, 0);
    chk("first_wr_ram_write", ram_write, 1);
    chk("first_wr_addr", ram_address, 11'h010);
    @(posedge clk); #1;
    m0_write = 0;

    // Single read
    c1 = rdv_cnt[1];
    acc(0, 0, 11'h010, 4'hF, '0, rd, waits);
    chk("single_rd_waits", waits, 0);
    chk("single_rd_data", rd, 32'hDEADBEEF);
    chk("single_rd_m1_rdv", rdv_cnt[1] - c1, 0);

    // Contention: both read 8 words
    c0 = rdv_cnt[0]; c1 = rdv_cnt[1];
    @(posedge clk); #1;
    i0 = 0; i1 = 0; prev_w = -1; alt_ok = 1;
    m0_read = 1; m0_address = 11'h000; m0_byteenable = 4'hF;
    m1_read = 1; m1_address = 11'h7F8; m1_byteenable = 4'hF;
    for (int n = 0; n < 40 && (i0 < 8 || i1 < 8); n++) begin
      @(negedge clk);
      a0 = m0_read && !m0_waitrequest;
      a1 = m1_read && !m1_waitrequest;
      chk("cont_cs", ram_chipselect, 1);
      cur_w = a0 ? 0 : (a1 ? 1 : -1);
      if (m0_read && m1_read && prev_w >= 0 && cur_w == prev_w) alt_ok = 0;
      prev_w = cur_w;
      @(posedge clk); #1;
      if (a0) begin i0++; if (i0 == 8) m0_read = 0; else m0_address = 11'(i0); end
      if (a1) begin i1++; if (i1 == 8) m1_read = 0; else m1_address = 11'h7F8 + 11'(i1); end
    end
    m0_read = 0; m1_read = 0;
    chk("cont_alternate", alt_ok, 1);
    @(negedge clk);
    @(negedge clk);
    chk("cont_m0_beats", rdv_cnt[0] - c0, 8);
    chk("cont_m1_beats", rdv_cnt[1] - c1, 8);

    // Byte lanes
    acc(1, 1, 11'h020, 4'hF, 32'h11223344, rd, waits);
    acc(1, 1, 11'h020, 4'h1, 32'h000000AA, rd, waits);
    acc(1, 0, 11'h020, 4'hF, '0, rd, waits);
    chk("byte_lane_data", rd, 32'h112233AA);
    acc(0, 0, 11'h7FF, 4'hF, '0, rd, waits);
    chk("init_word_7ff", rd, 32'hC0DE07FF);

    // Reset mid-read
    @(posedge clk); #1;
    m1_read = 1; m1_address = 11'h030; m1_byteenable = 4'hF;
    @(negedge clk);
    chk("midrd_accept", m1_waitrequest, 0);
    @(posedge clk); #1;
    reset_n = 0; m1_read = 0;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (m1_readdatavalid) pulses++; end
    @(posedge clk); #1;
    reset_n = 1;
    repeat (3) begin @(negedge clk); if (m1_readdatavalid) pulses++; end
    chk("midrd_dropped", pulses, 0);

`ifdef SYSTEM_RAM_ARB_LOCK_EN
    acc(0, 1, 11'h040, 4'hF, 32'h5A5A5A5A, rd, waits);
    @(posedge clk); #1;
    m0_lock = 1; m1_read = 1; m1_address = 11'h040; m1_byteenable = 4'hF;
    repeat (4) begin
      @(negedge clk);
      chk("lock_m1_held", m1_waitrequest, 1);
    end
    @(posedge clk); #1;
    m0_lock = 0;
    @(negedge clk);
    chk("lock_release_grant", m1_waitrequest, 0);
    @(posedge clk); #1;
    m1_read = 0;
    @(negedge clk);
    chk("lock_release_rdv", m1_readdatavalid, 1);
    chk("lock_release_data", m1_readdata, 32'h5A5A5A5A);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
